// File: rtl/frame_bank_scheduler_pkg.sv
// Shared types for the disparity frame bank scheduler.
//   bank_state_t : life cycle of one frame BRAM bank
//   rd_state_t   : output reader sequencing FSM states
//   NUM_BANKS    : number of ping-pong banks (fixed at two)
//   pick_read_bank : which FULL bank the reader drains next
package frame_bank_pkg;

    localparam int NUM_BANKS = 2;

    typedef enum logic [1:0] {
        FREE    = 2'd0,
        WRITING = 2'd1,
        FULL    = 2'd2,
        READING = 2'd3
    } bank_state_t;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_START     = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_ACTIVE    = 2'd3
    } rd_state_t;

    // With both banks FULL the first-completed one goes out first; otherwise
    // the single FULL bank is taken. Only meaningful when at least one is FULL.
    function automatic logic pick_read_bank(input bank_state_t st0,
                                            input bank_state_t st1,
                                            input logic        oldest);
        if (st0 == FULL && st1 == FULL) begin
            return oldest;
        end else if (st0 == FULL) begin
            return 1'b0;
        end else begin
            return 1'b1;
        end
    endfunction

endpackage

// File: rtl/frame_bank_scheduler_if.sv
// Handshake bundle between the bank scheduler and its two clients.
//   wr_bank, wr_enable      : scheduler -> filter writer (bank to fill, permission)
//   wr_frame_done           : filter writer -> scheduler (1-cycle frame completion)
//   rd_start, rd_bank       : scheduler -> output reader (start pulse, bank index)
//   rd_idle                 : output reader -> scheduler (reader idle status)
// master = scheduler side, slave = writer/reader side.
interface frame_bank_scheduler_if;
    logic wr_bank;
    logic wr_enable;
    logic wr_frame_done;
    logic rd_start;
    logic rd_bank;
    logic rd_idle;

    modport master (
        output wr_bank,
        output wr_enable,
        input  wr_frame_done,
        output rd_start,
        output rd_bank,
        input  rd_idle
    );

    modport slave (
        input  wr_bank,
        input  wr_enable,
        output wr_frame_done,
        input  rd_start,
        input  rd_bank,
        output rd_idle
    );
endinterface

// File: rtl/frame_bank_scheduler_sat_counter.sv
// Saturating event counter used for the frame statistics.
//   clk   : clock
//   clear : synchronous clear to zero (takes priority over inc)
//   inc   : count one event this cycle
//   count : registered count, holds at all-ones instead of wrapping
module sat_counter #(
    parameter int CNT_BITS = 16
) (
    input  logic                clk,
    input  logic                clear,
    input  logic                inc,
    output logic [CNT_BITS-1:0] count
);

    logic [CNT_BITS-1:0] count_r;

    // Count register: clear, saturating increment, or hold.
    always_ff @(posedge clk) begin
        if (clear) begin
            count_r <= {CNT_BITS{1'b0}};
        end else if (inc && (count_r != {CNT_BITS{1'b1}})) begin
            count_r <= count_r + {{(CNT_BITS-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/frame_bank_scheduler.sv
// Ping-pong scheduler for the two disparity frame BRAM banks. Hands the
// filter writer a free bank, marks it FULL when the frame completes, then
// starts the output reader on it and frees it when the reader goes idle.
//   clk, reset      : clock, synchronous active-high reset
//   bus (master)    : writer/reader handshake, see frame_bank_scheduler_if
//   frames_written  : completed writer frames (saturating)
//   frames_read     : completed reader frames (saturating)
//   frames_dropped  : FULL frames overwritten when DROP_OLDEST=1 (saturating)
//   busy            : a bank other than the writer's is in use, or reader active
module frame_bank_scheduler
    import frame_bank_pkg::*;
#(
    parameter int DROP_OLDEST = 0,
    parameter int CNT_BITS    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    frame_bank_scheduler_if.master bus,
    output logic [CNT_BITS-1:0]   frames_written,
    output logic [CNT_BITS-1:0]   frames_read,
    output logic [CNT_BITS-1:0]   frames_dropped,
    output logic                  busy
);

    bank_state_t bank_r     [NUM_BANKS];
    bank_state_t bank_nxt_s [NUM_BANKS];
    rd_state_t   rd_state_r;

    logic wr_bank_r;
    logic wr_enable_r;
    logic oldest_r;
    logic rd_start_r;
    logic rd_bank_r;
    logic busy_r;

    logic wr_bank_nxt_s;
    logic wr_enable_nxt_s;
    logic oldest_nxt_s;
    logic other_s;
    logic free_s;
    logic done_s;
    logic drop_s;
    logic launch_s;
    logic launch_bank_s;
    logic rd_busy_nxt_s;
    logic busy_nxt_s;

    // Next bank ownership. Order inside one cycle: reader free, then writer
    // completion (so a freed bank is immediately reusable), then reader
    // launch (so a bank completed this cycle can start next cycle).
    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_nxt_s[b] = bank_r[b];
        end
        wr_bank_nxt_s   = wr_bank_r;
        wr_enable_nxt_s = wr_enable_r;
        oldest_nxt_s    = oldest_r;
        drop_s          = 1'b0;
        launch_s        = 1'b0;
        launch_bank_s   = 1'b0;
        other_s         = ~wr_bank_r;
        free_s          = (rd_state_r == S_ACTIVE) && bus.rd_idle;
        done_s          = bus.wr_frame_done && wr_enable_r;

        if (free_s) begin
            bank_nxt_s[rd_bank_r] = FREE;
        end else begin
            bank_nxt_s[rd_bank_r] = bank_r[rd_bank_r];
        end

        if (done_s) begin
            bank_nxt_s[wr_bank_r] = FULL;
            // oldest only moves when the just-done bank is the sole FULL one
            if (bank_nxt_s[other_s] != FULL) begin
                oldest_nxt_s = wr_bank_r;
            end else begin
                oldest_nxt_s = oldest_r;
            end
            case (bank_nxt_s[other_s])
                FREE: begin
                    bank_nxt_s[other_s] = WRITING;
                    wr_bank_nxt_s       = other_s;
                end
                FULL: begin
                    if (DROP_OLDEST != 0) begin
                        bank_nxt_s[other_s] = WRITING;
                        wr_bank_nxt_s       = other_s;
                        drop_s              = 1'b1;
                        oldest_nxt_s        = wr_bank_r;
                    end else begin
                        wr_enable_nxt_s = 1'b0;
                    end
                end
                default: begin
                    wr_enable_nxt_s = 1'b0;
                end
            endcase
        end else if (!wr_enable_r && free_s) begin
            // stalled writer grabs the bank the reader just released
            bank_nxt_s[rd_bank_r] = WRITING;
            wr_bank_nxt_s         = rd_bank_r;
            wr_enable_nxt_s       = 1'b1;
        end else begin
            wr_enable_nxt_s = wr_enable_r;
        end

        if ((rd_state_r == S_IDLE) && bus.rd_idle &&
            ((bank_nxt_s[0] == FULL) || (bank_nxt_s[1] == FULL))) begin
            launch_s                  = 1'b1;
            launch_bank_s             = pick_read_bank(bank_nxt_s[0], bank_nxt_s[1], oldest_nxt_s);
            bank_nxt_s[launch_bank_s] = READING;
        end else begin
            launch_s = 1'b0;
        end
    end

    // Registered busy: reader activity next cycle plus any bank held outside the writer.
    always_comb begin
        case (rd_state_r)
            S_IDLE:      rd_busy_nxt_s = launch_s;
            S_START:     rd_busy_nxt_s = 1'b1;
            S_WAIT_BUSY: rd_busy_nxt_s = 1'b1;
            S_ACTIVE:    rd_busy_nxt_s = !bus.rd_idle;
            default:     rd_busy_nxt_s = 1'b0;
        endcase
        busy_nxt_s = rd_busy_nxt_s
                  || ((bank_nxt_s[0] != FREE) && !(wr_enable_nxt_s && !wr_bank_nxt_s))
                  || ((bank_nxt_s[1] != FREE) && !(wr_enable_nxt_s &&  wr_bank_nxt_s));
    end

    // Bank state, writer outputs and reader sequencing FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            bank_r[0]   <= WRITING;
            bank_r[1]   <= FREE;
            wr_bank_r   <= 1'b0;
            wr_enable_r <= 1'b1;
            oldest_r    <= 1'b0;
            rd_state_r  <= S_IDLE;
            rd_start_r  <= 1'b0;
            rd_bank_r   <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                bank_r[b] <= bank_nxt_s[b];
            end
            wr_bank_r   <= wr_bank_nxt_s;
            wr_enable_r <= wr_enable_nxt_s;
            oldest_r    <= oldest_nxt_s;
            busy_r      <= busy_nxt_s;
            case (rd_state_r)
                S_IDLE: begin
                    if (launch_s) begin
                        rd_start_r <= 1'b1;
                        rd_bank_r  <= launch_bank_s;
                        rd_state_r <= S_START;
                    end else begin
                        rd_start_r <= 1'b0;
                    end
                end
                S_START: begin
                    rd_start_r <= 1'b0;
                    rd_state_r <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    rd_start_r <= 1'b0;
                    if (!bus.rd_idle) begin
                        rd_state_r <= S_ACTIVE;
                    end else begin
                        rd_state_r <= S_WAIT_BUSY;
                    end
                end
                S_ACTIVE: begin
                    rd_start_r <= 1'b0;
                    if (bus.rd_idle) begin
                        rd_state_r <= S_IDLE;
                    end else begin
                        rd_state_r <= S_ACTIVE;
                    end
                end
                default: begin
                    rd_start_r <= 1'b0;
                    rd_state_r <= S_IDLE;
                end
            endcase
        end
    end

    sat_counter #(.CNT_BITS(CNT_BITS)) u_cnt_written (
        .clk   (clk),
        .clear (reset),
        .inc   (done_s),
        .count (frames_written)
    );

    sat_counter #(.CNT_BITS(CNT_BITS)) u_cnt_read (
        .clk   (clk),
        .clear (reset),
        .inc   (free_s),
        .count (frames_read)
    );

    sat_counter #(.CNT_BITS(CNT_BITS)) u_cnt_dropped (
        .clk   (clk),
        .clear (reset),
        .inc   (drop_s),
        .count (frames_dropped)
    );

    assign bus.wr_bank   = wr_bank_r;
    assign bus.wr_enable = wr_enable_r;
    assign bus.rd_start  = rd_start_r;
    assign bus.rd_bank   = rd_bank_r;
    assign busy          = busy_r;

endmodule

// File: tb/tb_frame_bank_scheduler.sv
// Bench for frame_bank_scheduler. Three instances share one directed input
// stream: A (DROP_OLDEST=0), B (DROP_OLDEST=1), C (DROP_OLDEST=0, 4-bit
// counters). A frame-level model tracks each instance and every output is
// compared each cycle; a set of literal checks pins key scenario values.
module tb_frame_bank_scheduler;

    localparam int M_FREE = 0;
    localparam int M_WR   = 1;
    localparam int M_FULL = 2;
    localparam int M_RD   = 3;

    logic clk;
    logic rst_v;
    int   vectors;
    int   miscompares;

    frame_bank_scheduler_if ifa ();
    frame_bank_scheduler_if ifb ();
    frame_bank_scheduler_if ifc ();

    logic [15:0] fw_a, fr_a, fd_a;
    logic [15:0] fw_b, fr_b, fd_b;
    logic [3:0]  fw_c, fr_c, fd_c;
    logic        busy_a, busy_b, busy_c;

    frame_bank_scheduler #(.DROP_OLDEST(0), .CNT_BITS(16)) dut_a (
        .clk(clk), .reset(rst_v), .bus(ifa),
        .frames_written(fw_a), .frames_read(fr_a), .frames_dropped(fd_a), .busy(busy_a));
    frame_bank_scheduler #(.DROP_OLDEST(1), .CNT_BITS(16)) dut_b (
        .clk(clk), .reset(rst_v), .bus(ifb),
        .frames_written(fw_b), .frames_read(fr_b), .frames_dropped(fd_b), .busy(busy_b));
    frame_bank_scheduler #(.DROP_OLDEST(0), .CNT_BITS(4)) dut_c (
        .clk(clk), .reset(rst_v), .bus(ifc),
        .frames_written(fw_c), .frames_read(fr_c), .frames_dropped(fd_c), .busy(busy_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // model state per instance: bank usage, completion stamps, reader phase
    int ms     [3][2];
    int mstamp [3][2];
    int mwb[3], men[3], mph[3], mrb[3], mrs[3], mseq[3];
    int mfw[3], mfr[3], mfd[3];
    int mdrop[3] = '{0, 1, 0};
    int mmax [3] = '{65535, 65535, 15};

    task automatic chk(input string nm, input int k, input logic [15:0] act, input logic [15:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s dut%0d: got %0h, expected %0h at %0t", nm, k, act, expv, $time);
        end
    endtask

    // One clock edge of the frame-level rules for instance k.
    task automatic model_step(input int k, input logic done, input logic idle, input logic rst);
        int ph0, freed, w, o, best;
        if (rst) begin
            ms[k][0] = M_WR; ms[k][1] = M_FREE;
            mstamp[k][0] = 0; mstamp[k][1] = 0;
            mwb[k] = 0; men[k] = 1; mph[k] = 0; mrb[k] = 0; mrs[k] = 0; mseq[k] = 0;
            mfw[k] = 0; mfr[k] = 0; mfd[k] = 0;
        end else begin
            ph0   = mph[k];
            freed = -1;
            if (ph0 == 3 && idle) begin
                ms[k][mrb[k]] = M_FREE;
                freed = mrb[k];
                if (mfr[k] < mmax[k]) mfr[k]++;
            end
            if (done && men[k] == 1) begin
                w = mwb[k];
                o = 1 - w;
                ms[k][w] = M_FULL;
                mseq[k]++;
                mstamp[k][w] = mseq[k];
                if (mfw[k] < mmax[k]) mfw[k]++;
                if (ms[k][o] == M_FREE) begin
                    ms[k][o] = M_WR; mwb[k] = o;
                end else if (ms[k][o] == M_FULL && mdrop[k] == 1) begin
                    ms[k][o] = M_WR; mwb[k] = o;
                    if (mfd[k] < mmax[k]) mfd[k]++;
                end else begin
                    men[k] = 0;
                end
            end else if (men[k] == 0 && freed >= 0) begin
                ms[k][freed] = M_WR; mwb[k] = freed; men[k] = 1;
            end
            mrs[k] = 0;
            case (ph0)
                0: begin
                    best = -1;
                    for (int b = 0; b < 2; b++) begin
                        if (ms[k][b] == M_FULL && (best < 0 || mstamp[k][b] < mstamp[k][best])) best = b;
                    end
                    if (idle && best >= 0) begin
                        ms[k][best] = M_RD; mrb[k] = best; mrs[k] = 1; mph[k] = 1;
                    end
                end
                1: mph[k] = 2;
                2: if (!idle) mph[k] = 3;
                default: if (idle) mph[k] = 0;
            endcase
        end
    endtask

    task automatic compare_all();
        logic [15:0] a_wb, a_we, a_rs, a_rb, a_fw, a_fr, a_fd, a_bz;
        int eb;
        for (int k = 0; k < 3; k++) begin
            case (k)
                0: begin
                    a_wb = {15'd0, ifa.wr_bank}; a_we = {15'd0, ifa.wr_enable};
                    a_rs = {15'd0, ifa.rd_start}; a_rb = {15'd0, ifa.rd_bank};
                    a_fw = fw_a; a_fr = fr_a; a_fd = fd_a; a_bz = {15'd0, busy_a};
                end
                1: begin
                    a_wb = {15'd0, ifb.wr_bank}; a_we = {15'd0, ifb.wr_enable};
                    a_rs = {15'd0, ifb.rd_start}; a_rb = {15'd0, ifb.rd_bank};
                    a_fw = fw_b; a_fr = fr_b; a_fd = fd_b; a_bz = {15'd0, busy_b};
                end
                default: begin
                    a_wb = {15'd0, ifc.wr_bank}; a_we = {15'd0, ifc.wr_enable};
                    a_rs = {15'd0, ifc.rd_start}; a_rb = {15'd0, ifc.rd_bank};
                    a_fw = {12'd0, fw_c}; a_fr = {12'd0, fr_c}; a_fd = {12'd0, fd_c};
                    a_bz = {15'd0, busy_c};
                end
            endcase
            eb = (mph[k] != 0) ? 1 : 0;
            for (int b = 0; b < 2; b++) begin
                if (ms[k][b] != M_FREE && !(men[k] == 1 && mwb[k] == b)) eb = 1;
            end
            chk("wr_bank",        k, a_wb, 16'(mwb[k]));
            chk("wr_enable",      k, a_we, 16'(men[k]));
            chk("rd_start",       k, a_rs, 16'(mrs[k]));
            chk("rd_bank",        k, a_rb, 16'(mrb[k]));
            chk("frames_written", k, a_fw, 16'(mfw[k]));
            chk("frames_read",    k, a_fr, 16'(mfr[k]));
            chk("frames_dropped", k, a_fd, 16'(mfd[k]));
            chk("busy",           k, a_bz, 16'(eb));
            if (mph[k] >= 2 && men[k] == 1) begin
                chk("wr_bank_ne_rd_bank", k, {15'd0, (a_wb != a_rb)}, 16'd1);
            end
        end
    endtask

    task automatic cycle(input logic d, input logic idl, input logic r);
        ifa.wr_frame_done = d; ifb.wr_frame_done = d; ifc.wr_frame_done = d;
        ifa.rd_idle = idl;     ifb.rd_idle = idl;     ifc.rd_idle = idl;
        rst_v = r;
        @(posedge clk);
        for (int k = 0; k < 3; k++) model_step(k, d, idl, r);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;

        // reset
        cycle(1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 1'b1);
        chk("pin_rst_wr_enable", 0, {15'd0, ifa.wr_enable}, 16'd1);
        chk("pin_rst_wr_bank",   0, {15'd0, ifa.wr_bank},   16'd0);
        chk("pin_rst_busy",      0, {15'd0, busy_a},        16'd0);

        // first frame: reader starts on bank0 the cycle after done
        repeat (3) cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        chk("pin_first_wr_bank",  0, {15'd0, ifa.wr_bank},  16'd1);
        chk("pin_first_rd_start", 0, {15'd0, ifa.rd_start}, 16'd1);
        chk("pin_first_rd_bank",  0, {15'd0, ifa.rd_bank},  16'd0);
        chk("pin_first_fw",       0, fw_a,                  16'd1);

        // reader busy; second done stalls the writer, third is ignored
        cycle(1'b0, 1'b1, 1'b0);
        chk("pin_start_pulse_end", 0, {15'd0, ifa.rd_start}, 16'd0);
        repeat (4) cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        chk("pin_stall_a", 0, {15'd0, ifa.wr_enable}, 16'd0);
        chk("pin_stall_b", 1, {15'd0, ifb.wr_enable}, 16'd0);
        repeat (4) cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        repeat (4) cycle(1'b0, 1'b0, 1'b0);
        chk("pin_ignored_done_fw", 0, fw_a, 16'd2);
        cycle(1'b0, 1'b1, 1'b0);
        chk("pin_unstall_en", 0, {15'd0, ifa.wr_enable}, 16'd1);
        chk("pin_unstall_wb", 0, {15'd0, ifa.wr_bank},   16'd0);
        chk("pin_unstall_fr", 0, fr_a,                   16'd1);
        cycle(1'b0, 1'b1, 1'b0);
        chk("pin_second_rd_start", 0, {15'd0, ifa.rd_start}, 16'd1);
        chk("pin_second_rd_bank",  0, {15'd0, ifa.rd_bank},  16'd1);

        // reader finishes in the same cycle the writer completes
        cycle(1'b0, 1'b1, 1'b0);
        repeat (3) cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        chk("pin_simul_en", 0, {15'd0, ifa.wr_enable}, 16'd1);
        chk("pin_simul_wb", 0, {15'd0, ifa.wr_bank},   16'd1);
        chk("pin_simul_fw", 0, fw_a,                   16'd3);
        chk("pin_simul_fr", 0, fr_a,                   16'd2);
        cycle(1'b0, 1'b1, 1'b0);
        chk("pin_simul_rd_bank", 0, {15'd0, ifa.rd_bank}, 16'd0);
        cycle(1'b0, 1'b1, 1'b0);
        repeat (3) cycle(1'b0, 1'b0, 1'b0);

        // reset while the reader is active
        cycle(1'b0, 1'b0, 1'b1);
        chk("pin_midrst_fw",   0, fw_a,                   16'd0);
        chk("pin_midrst_busy", 0, {15'd0, busy_a},        16'd0);
        repeat (3) cycle(1'b0, 1'b1, 1'b0);
        chk("pin_midrst_no_start", 0, {15'd0, ifa.rd_start}, 16'd0);

        // reader held off: three dones, B drops, A stalls
        cycle(1'b1, 1'b0, 1'b0);
        repeat (2) cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        repeat (2) cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        chk("pin_drop_a_en", 0, {15'd0, ifa.wr_enable}, 16'd0);
        chk("pin_drop_a_fw", 0, fw_a,                   16'd2);
        chk("pin_drop_b_en", 1, {15'd0, ifb.wr_enable}, 16'd1);
        chk("pin_drop_b_wb", 1, {15'd0, ifb.wr_bank},   16'd1);
        chk("pin_drop_b_fd", 1, fd_b,                   16'd2);
        chk("pin_drop_b_fw", 1, fw_b,                   16'd3);
        cycle(1'b0, 1'b1, 1'b0);
        chk("pin_oldest_a_rd_bank", 0, {15'd0, ifa.rd_bank}, 16'd0);
        chk("pin_oldest_b_rd_bank", 1, {15'd0, ifb.rd_bank}, 16'd0);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        chk("pin_drain_a_wb", 0, {15'd0, ifa.wr_bank}, 16'd0);
        cycle(1'b0, 1'b1, 1'b0);
        chk("pin_drain_a_rd_bank", 0, {15'd0, ifa.rd_bank}, 16'd1);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);

        // saturation: 20 full write/read round trips
        cycle(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 1'b1, 1'b0);
            cycle(1'b0, 1'b1, 1'b0);
            cycle(1'b0, 1'b0, 1'b0);
            cycle(1'b0, 1'b1, 1'b0);
        end
        chk("pin_sat_a_fw", 0, fw_a,          16'd20);
        chk("pin_sat_a_fr", 0, fr_a,          16'd20);
        chk("pin_sat_c_fw", 2, {12'd0, fw_c}, 16'd15);
        chk("pin_sat_c_fr", 2, {12'd0, fr_c}, 16'd15);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
